instr_mem_loader: RTL and testbench

Parametrised instruction memory for the processor fetch stage, loaded at run time rather than fixed at elaboration. A byte-serial loader, fed by the host or UART front end, assembles instruction words and writes them from a base address. The fetch port returns one word per request with one-cycle latency, and is gated until a load has completed successfully.

---
 rtl/instr_mem_pkg.sv | 19 +
 rtl/instr_mem_array.sv | 29 ++
 rtl/instr_mem_loader.sv | 185 ++++++++++++++++++
 tb/tb_instr_mem_loader.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared definitions for the run-time loadable instruction memory:
// loader states, word geometry and the default out-of-range fetch word.
package instr_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } load_state_e;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int BYTES_PER_WORD = DEFAULT_DATA_WIDTH / 8;
    localparam logic [DEFAULT_DATA_WIDTH-1:0] DEFAULT_NOP_WORD = '0;

    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Single-clock word memory with one synchronous write port and one registered
// read port, shaped for block-RAM inference (no reset on array or read data).
module instr_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Read data only moves on an enabled read, so it holds across idle cycles.
    always_ff @(posedge clock_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory with a byte-serial run-time loader and a gated fetch port
// that returns one word per request with one-cycle latency.
module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024,
    parameter bit BIG_ENDIAN = 1'b1,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(DEFAULT_NOP_WORD)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH:0]   load_count,
    input  logic                  load_valid,
    input  logic [7:0]            load_byte,
    output logic                  load_ready,
    output logic                  load_done,
    output logic                  load_error,
    output logic                  program_ready,
    input  logic                  fetch_en,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  fetch_valid,
    output logic                  fetch_fault
);

    localparam int BPW = bytes_per_word(DATA_WIDTH);
    localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int CW  = ADDR_WIDTH + 1;

    load_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         word_idx_q, word_idx_d;
    logic [BIW-1:0]        byte_idx_q, byte_idx_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic                  prog_q, prog_d;
    logic                  zero_done_q, zero_done_d;
    logic                  error_q, error_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [ADDR_WIDTH+1:0] load_end;
    logic                  last_byte;

    logic                  fetch_take;
    logic                  fetch_oob;
    logic                  valid_q;
    logic                  fault_q;
    logic                  nop_sel_q;
    logic                  data_zero_q;

    // Extra headroom bit so base + count cannot wrap before the range check.
    assign load_end  = {2'b00, load_base} + {1'b0, load_count};
    assign last_byte = (byte_idx_q == BIW'(BPW - 1));
    assign mem_waddr = base_q + word_idx_q[ADDR_WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        word_idx_d  = word_idx_q;
        byte_idx_d  = byte_idx_q;
        asm_d       = asm_q;
        prog_d      = prog_q;
        zero_done_d = 1'b0;
        error_d     = 1'b0;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    if (load_count == '0) begin
                        zero_done_d = 1'b1;
                        prog_d      = 1'b1;
                    end else if (load_end > (ADDR_WIDTH + 2)'(DEPTH)) begin
                        error_d = 1'b1;
                        prog_d  = 1'b0;
                    end else begin
                        base_d     = load_base;
                        count_d    = load_count;
                        word_idx_d = '0;
                        byte_idx_d = '0;
                        asm_d      = '0;
                        prog_d     = 1'b0;
                        state_d    = LOAD;
                    end
                end
            end
            LOAD: begin
                if (load_valid) begin
                    asm_d = BIG_ENDIAN ? ((asm_q << 8) | DATA_WIDTH'(load_byte))
                                       : ((asm_q >> 8) | (DATA_WIDTH'(load_byte) << (DATA_WIDTH - 8)));
                    if (last_byte) begin
                        mem_we     = 1'b1;
                        byte_idx_d = '0;
                        word_idx_d = word_idx_q + CW'(1);
                        if (word_idx_d == count_q) begin
                            state_d = DONE;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + BIW'(1);
                    end
                end
            end
            DONE: begin
                prog_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            count_q     <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            asm_q       <= '0;
            prog_q      <= 1'b0;
            zero_done_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            asm_q       <= asm_d;
            prog_q      <= prog_d;
            zero_done_q <= zero_done_d;
            error_q     <= error_d;
        end
    end

    assign load_ready    = (state_q == LOAD);
    assign load_done     = zero_done_q | (state_q == DONE);
    assign load_error    = error_q;
    assign program_ready = prog_q;

    assign fetch_take = fetch_en && prog_q;
    assign fetch_oob  = ({1'b0, fetch_addr} >= CW'(DEPTH));

    // The RAM read register has no reset, so the output mux supplies the reset
    // zero and the NOP word, and only an accepted fetch re-steers it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q     <= 1'b0;
            fault_q     <= 1'b0;
            nop_sel_q   <= 1'b0;
            data_zero_q <= 1'b1;
        end else begin
            valid_q <= fetch_take;
            fault_q <= fetch_take && fetch_oob;
            if (fetch_take) begin
                nop_sel_q   <= fetch_oob;
                data_zero_q <= 1'b0;
            end
        end
    end

    assign fetch_valid = valid_q;
    assign fetch_fault = fault_q;
    assign fetch_data  = data_zero_q ? '0 : (nop_sel_q ? NOP_WORD : mem_rdata);

    instr_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clock_i   (clock),
        .wr_en_i   (mem_we),
        .wr_addr_i (mem_waddr),
        .wr_data_i (asm_d),
        .rd_en_i   (fetch_take && !fetch_oob),
        .rd_addr_i (fetch_addr),
        .rd_data_o (mem_rdata)
    );

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: two instances (big-endian full depth, little-endian
// DEPTH=1000 with a distinct NOP word) driven by shared stimulus.
module tb_instr_mem_loader;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          load_start;
    logic [AW-1:0] load_base;
    logic [AW:0]   load_count;
    logic          load_valid;
    logic [7:0]    load_byte;
    logic          fetch_en;
    logic [AW-1:0] fetch_addr;

    logic [1:0]    loadReady, loadDone, loadError, programReady, fetchValid, fetchFault;
    logic [DW-1:0] fetchData [2];

    int total = 0;
    int bad   = 0;
    bit checkEn = 1'b0;

    always #5 clock = ~clock;

    instr_mem_loader #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(1024), .BIG_ENDIAN(1'b1), .NOP_WORD(32'h0)
    ) dutA (
        .clock(clock), .reset_n(reset_n), .load_start(load_start), .load_base(load_base),
        .load_count(load_count), .load_valid(load_valid), .load_byte(load_byte),
        .load_ready(loadReady[0]), .load_done(loadDone[0]), .load_error(loadError[0]),
        .program_ready(programReady[0]), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
        .fetch_data(fetchData[0]), .fetch_valid(fetchValid[0]), .fetch_fault(fetchFault[0])
    );

    instr_mem_loader #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(1000), .BIG_ENDIAN(1'b0), .NOP_WORD(32'h0000_0013)
    ) dutB (
        .clock(clock), .reset_n(reset_n), .load_start(load_start), .load_base(load_base),
        .load_count(load_count), .load_valid(load_valid), .load_byte(load_byte),
        .load_ready(loadReady[1]), .load_done(loadDone[1]), .load_error(loadError[1]),
        .program_ready(programReady[1]), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
        .fetch_data(fetchData[1]), .fetch_valid(fetchValid[1]), .fetch_fault(fetchFault[1])
    );

    function automatic int depthOf(input int k);
        return (k == 0) ? 1024 : 1000;
    endfunction

    function automatic bit beOf(input int k);
        return (k == 0);
    endfunction

    function automatic logic [31:0] nopOf(input int k);
        return (k == 0) ? 32'h0 : 32'h0000_0013;
    endfunction

    // Reference model: phase 0 idle, 1 receiving bytes, 2 completion cycle.
    logic [31:0] mMem   [2][1024];
    bit          mKnown [2][1024];
    logic [7:0]  mBuf   [2][4];
    int          mPhase [2];
    int          mBase  [2];
    int          mCount [2];
    int          mWords [2];
    int          mNb    [2];
    bit          eReady [2];
    bit          eDone  [2];
    bit          eErr   [2];
    bit          eProg  [2];
    bit          eValid [2];
    bit          eFault [2];
    logic [31:0] eData  [2];
    bit          eKnown [2];

    task automatic modelStep(input int k);
        bit          take;
        bit          oob;
        logic [31:0] word;
        int          addr;
        take = fetch_en && eProg[k];
        oob  = (int'(fetch_addr) >= depthOf(k));
        eValid[k] = take;
        eFault[k] = take && oob;
        if (take) begin
            if (oob) begin
                eData[k]  = nopOf(k);
                eKnown[k] = 1'b1;
            end else begin
                eData[k]  = mMem[k][fetch_addr];
                eKnown[k] = mKnown[k][fetch_addr];
            end
        end
        eDone[k] = 1'b0;
        eErr[k]  = 1'b0;
        case (mPhase[k])
            0: begin
                if (load_start) begin
                    if (load_count == 0) begin
                        eDone[k] = 1'b1;
                        eProg[k] = 1'b1;
                    end else if (int'(load_base) + int'(load_count) > depthOf(k)) begin
                        eErr[k]  = 1'b1;
                        eProg[k] = 1'b0;
                    end else begin
                        mPhase[k] = 1;
                        mBase[k]  = int'(load_base);
                        mCount[k] = int'(load_count);
                        mWords[k] = 0;
                        mNb[k]    = 0;
                        eProg[k]  = 1'b0;
                    end
                end
            end
            1: begin
                if (load_valid) begin
                    mBuf[k][mNb[k]] = load_byte;
                    mNb[k]++;
                    if (mNb[k] == 4) begin
                        word = beOf(k) ? {mBuf[k][0], mBuf[k][1], mBuf[k][2], mBuf[k][3]}
                                       : {mBuf[k][3], mBuf[k][2], mBuf[k][1], mBuf[k][0]};
                        addr = mBase[k] + mWords[k];
                        mMem[k][addr]   = word;
                        mKnown[k][addr] = 1'b1;
                        mWords[k]++;
                        mNb[k] = 0;
                        if (mWords[k] == mCount[k]) begin
                            mPhase[k] = 2;
                            eDone[k]  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                mPhase[k] = 0;
                eProg[k]  = 1'b1;
            end
        endcase
        eReady[k] = (mPhase[k] == 1);
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                mPhase[k] = 0;
                mNb[k]    = 0;
                eReady[k] = 1'b0;
                eDone[k]  = 1'b0;
                eErr[k]   = 1'b0;
                eProg[k]  = 1'b0;
                eValid[k] = 1'b0;
                eFault[k] = 1'b0;
                eData[k]  = 32'h0;
                eKnown[k] = 1'b1;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                modelStep(k);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        if (checkEn) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("load_ready[%0d]", k), 32'(loadReady[k]), 32'(eReady[k]));
                checkOutput($sformatf("load_done[%0d]", k), 32'(loadDone[k]), 32'(eDone[k]));
                checkOutput($sformatf("load_error[%0d]", k), 32'(loadError[k]), 32'(eErr[k]));
                checkOutput($sformatf("program_ready[%0d]", k), 32'(programReady[k]), 32'(eProg[k]));
                checkOutput($sformatf("fetch_valid[%0d]", k), 32'(fetchValid[k]), 32'(eValid[k]));
                checkOutput($sformatf("fetch_fault[%0d]", k), 32'(fetchFault[k]), 32'(eFault[k]));
                if (eKnown[k]) begin
                    checkOutput($sformatf("fetch_data[%0d]", k), fetchData[k], eData[k]);
                end
            end
        end
    end

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic startLoad(input int base, input int cnt);
        load_start = 1'b1;
        load_base  = AW'(base);
        load_count = (AW + 1)'(cnt);
        nextCycle();
        load_start = 1'b0;
    endtask

    function automatic logic [AW-1:0] randAddr();
        if ($urandom_range(0, 9) < 7) begin
            return AW'($urandom_range(0, 47));
        end
        return AW'($urandom_range(990, 1023));
    endfunction

    task automatic streamBytes(input logic [7:0] bytes[$], input int gapMode, input bit randFetch);
        int idx   = 0;
        int guard = 0;
        bit tog   = 1'b0;
        bit v;
        while (idx < bytes.size() && guard < 2000) begin
            case (gapMode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = !tog; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            load_valid = v;
            load_byte  = v ? bytes[idx] : 8'($urandom);
            if (randFetch) begin
                fetch_en   = 1'($urandom_range(0, 1));
                fetch_addr = randAddr();
            end
            nextCycle();
            if (v) begin
                idx++;
            end
            guard++;
        end
        load_valid = 1'b0;
        fetch_en   = 1'b0;
    endtask

    task automatic applyStimulus(input int base, input int cnt, input logic [7:0] bytes[$],
                                 input int gapMode, input bit randFetch);
        startLoad(base, cnt);
        streamBytes(bytes, gapMode, randFetch);
        nextCycle();
    endtask

    task automatic fetchAt(input int addr);
        fetch_en   = 1'b1;
        fetch_addr = AW'(addr);
        nextCycle();
        fetch_en   = 1'b0;
    endtask

    initial begin
        logic [7:0] bytesA[$];
        logic [7:0] bytesR[$];
        logic [7:0] bytesX[$];
        int base;
        int cnt;

        reset_n    = 1'b0;
        load_start = 1'b0;
        load_base  = '0;
        load_count = '0;
        load_valid = 1'b0;
        load_byte  = '0;
        fetch_en   = 1'b1;
        fetch_addr = '0;
        repeat (2) @(posedge clock);
        #1;
        checkEn = 1'b1;
        nextCycle();
        reset_n = 1'b1;
        repeat (3) nextCycle();
        checkOutput("reset_fetch_valid", 32'(fetchValid), 32'h0);
        checkOutput("reset_program_ready", 32'(programReady), 32'h0);
        checkOutput("reset_load_ready", 32'(loadReady), 32'h0);
        checkOutput("reset_fetch_data", fetchData[0], 32'h0);
        fetch_en = 1'b0;

        bytesA = '{8'h48, 8'h00, 8'h00, 8'h08, 8'h58, 8'h20, 8'h00, 8'h00};
        startLoad(0, 2);
        checkOutput("load1_ready", 32'(loadReady), 32'h3);
        streamBytes(bytesA, 0, 1'b0);
        checkOutput("load1_done", 32'(loadDone), 32'h3);
        checkOutput("load1_ready_off", 32'(loadReady), 32'h0);
        nextCycle();
        checkOutput("load1_prog", 32'(programReady), 32'h3);
        checkOutput("load1_done_off", 32'(loadDone), 32'h0);
        fetchAt(1);
        checkOutput("fetch1_valid", 32'(fetchValid), 32'h3);
        checkOutput("fetch1_be", fetchData[0], 32'h58200000);
        checkOutput("fetch1_le", fetchData[1], 32'h00002058);
        fetchAt(0);
        checkOutput("fetch0_be", fetchData[0], 32'h48000008);
        checkOutput("fetch0_le", fetchData[1], 32'h08000048);

        startLoad(0, 2);
        streamBytes(bytesA, 1, 1'b0);
        nextCycle();
        fetchAt(0);
        checkOutput("gap_fetch0_be", fetchData[0], 32'h48000008);
        checkOutput("gap_fetch0_le", fetchData[1], 32'h08000048);
        fetchAt(1);
        checkOutput("gap_fetch1_be", fetchData[0], 32'h58200000);

        startLoad(1020, 5);
        checkOutput("ovf_error", 32'(loadError), 32'h3);
        checkOutput("ovf_prog", 32'(programReady), 32'h0);
        checkOutput("ovf_ready", 32'(loadReady), 32'h0);
        nextCycle();
        checkOutput("ovf_error_off", 32'(loadError), 32'h0);
        fetchAt(0);
        checkOutput("ovf_fetch_blocked", 32'(fetchValid), 32'h0);

        bytesR = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        applyStimulus(0, 1, bytesR, 2, 1'b0);

        bytesX = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        startLoad(20, 2);
        streamBytes(bytesX, 0, 1'b0);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_mid_ready", 32'(loadReady), 32'h0);
        checkOutput("rst_mid_prog", 32'(programReady), 32'h0);
        checkOutput("rst_mid_data", fetchData[1], 32'h0);
        nextCycle();
        nextCycle();
        reset_n = 1'b1;
        nextCycle();
        bytesX = '{8'h01, 8'h02, 8'h03, 8'h04};
        applyStimulus(40, 1, bytesX, 0, 1'b0);
        fetchAt(20);
        checkOutput("rst_kept_be", fetchData[0], 32'h11223344);
        checkOutput("rst_kept_le", fetchData[1], 32'h44332211);

        fetchAt(1010);
        checkOutput("oob_fault_b", 32'(fetchFault[1]), 32'h1);
        checkOutput("oob_nop_b", fetchData[1], 32'h00000013);
        checkOutput("inrange_fault_a", 32'(fetchFault[0]), 32'h0);
        checkOutput("oob_valid", 32'(fetchValid), 32'h3);
        fetchAt(0);
        checkOutput("back_fault", 32'(fetchFault), 32'h0);
        checkOutput("back_be", fetchData[0], 32'hDEADBEEF);
        checkOutput("back_le", fetchData[1], 32'hEFBEADDE);
        nextCycle();
        checkOutput("idle_valid", 32'(fetchValid), 32'h0);
        checkOutput("idle_hold_le", fetchData[1], 32'hEFBEADDE);

        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 2) != 0) begin
                base = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023))
                                                   : int'($urandom_range(0, 40));
                cnt = int'($urandom_range(0, 6));
                bytesR.delete();
                for (int b = 0; b < cnt * 4; b++) begin
                    bytesR.push_back(8'($urandom));
                end
                fetch_en   = 1'($urandom_range(0, 1));
                fetch_addr = randAddr();
                applyStimulus(base, cnt, bytesR, int'($urandom_range(0, 2)), 1'b1);
            end else begin
                repeat (12) begin
                    fetch_en   = 1'($urandom_range(0, 1));
                    fetch_addr = randAddr();
                    nextCycle();
                end
                fetch_en = 1'b0;
            end
        end
        nextCycle();
        nextCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
